// File: rtl/axi4_duth_noc_ni_flit_unpacker.sv
// NoC network-interface flit unpacker: reassembles one AXI channel word
// (ID excluded) from a head flit plus zero or more body flits, holds the
// word until downstream accepts it, and flags framing errors stickily.
module axi4_duth_noc_ni_flit_unpacker #(
  parameter int LINK_WIDTH   = 32,
  parameter int CHAN_W       = 67,
  parameter int HEADER_FULL  = 8,
  parameter int HEADER_SMALL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINK_WIDTH-1:0]  flit_in,
  input  logic                   flit_head_in,
  input  logic                   flit_tail_in,
  input  logic                   flit_valid_in,
  output logic                   flit_ready_out,
  output logic [CHAN_W-1:0]      chan_out,
  output logic [HEADER_FULL-1:0] hdr_out,
  output logic                   chan_valid_out,
  input  logic                   chan_ready_in,
  output logic                   err_out
);

  // Payload bits carried by head and body flits.
  localparam int PAY_H  = LINK_WIDTH - HEADER_FULL;
  localparam int PAY_B  = LINK_WIDTH - HEADER_SMALL;
  localparam int REM_W  = (CHAN_W > PAY_H) ? (CHAN_W - PAY_H) : 0;
  localparam int FLITS  = 1 + (REM_W + PAY_B - 1) / PAY_B;
  localparam int CNT_W  = $clog2(FLITS + 1);
  // Span of all payload slots including the padding in the last flit.
  localparam int WORD_W = PAY_H + (FLITS - 1) * PAY_B;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FLITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                 state_q, state_n;
  logic [CNT_W-1:0]       cnt_q, cnt_n;
  logic [CHAN_W-1:0]      chan_q;
  logic [CHAN_W-1:0]      chan_head;
  logic [CHAN_W-1:0]      chan_body;
  logic [HEADER_FULL-1:0] hdr_q;
  logic                   err_q;
  logic                   accept;
  logic                   load_head;
  logic                   load_body;
  logic                   set_err;

  // A pending word blocks the link only while downstream is stalled.
  assign flit_ready_out = (state_q != HOLD) | chan_ready_in;
  assign accept         = flit_valid_in & flit_ready_out;

  assign chan_out       = chan_q;
  assign hdr_out        = hdr_q;
  assign chan_valid_out = (state_q == HOLD);
  assign err_out        = err_q;

  // A head flit always starts a fresh word: everything above its payload is zero.
  assign chan_head = CHAN_W'(flit_in[LINK_WIDTH-1:HEADER_FULL]);

  // Body payload lands in the slot selected by the flit counter; bits past CHAN_W are padding.
  generate
    if (FLITS > 1) begin : g_body
      logic [WORD_W-1:0] spread;
      logic [WORD_W-1:0] word_ext;
      logic [WORD_W-1:0] mask;
      logic [WORD_W-1:0] merged;

      assign spread   = {{(FLITS-1){flit_in[LINK_WIDTH-1:HEADER_SMALL]}},
                         flit_in[LINK_WIDTH-1:HEADER_FULL]};
      assign word_ext = WORD_W'(chan_q);
      assign mask     = {{(WORD_W-PAY_B){1'b0}}, {PAY_B{1'b1}}}
                        << (PAY_H + (int'(cnt_q) - 1) * PAY_B);
      assign merged   = (word_ext & ~mask) | (spread & mask);
      assign chan_body = merged[CHAN_W-1:0];

      if (WORD_W > CHAN_W) begin : g_pad
        logic pad_unused;
        assign pad_unused = ^merged[WORD_W-1:CHAN_W];
      end
    end else begin : g_nobody
      assign chan_body = chan_q;
    end
  endgenerate

  // State and flit-counter register; reset discards any partial or pending word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next-state, load strobes and framing-error detection.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    load_head = 1'b0;
    load_body = 1'b0;
    set_err   = 1'b0;
    if (accept && flit_head_in) begin
      // Head flit: legal from IDLE or from HOLD while the old word drains.
      load_head = 1'b1;
      cnt_n     = CNT_ONE;
      if (state_q == BODY) begin
        set_err = 1'b1;
      end
      if (FLITS == 1) begin
        state_n = HOLD;
        if (!flit_tail_in) begin
          set_err = 1'b1;
        end
      end else if (flit_tail_in) begin
        state_n = HOLD;
        set_err = 1'b1;
      end else begin
        state_n = BODY;
      end
    end else if (accept && (state_q == BODY)) begin
      load_body = 1'b1;
      cnt_n     = cnt_q + CNT_ONE;
      if (cnt_q == LAST_CNT) begin
        state_n = HOLD;
        if (!flit_tail_in) begin
          set_err = 1'b1;
        end
      end else if (flit_tail_in) begin
        state_n = HOLD;
        set_err = 1'b1;
      end
    end else if (accept) begin
      // Body flit with no packet open: drop it. In HOLD this also means
      // downstream took the word this cycle.
      set_err = 1'b1;
      state_n = IDLE;
      cnt_n   = '0;
    end else if ((state_q == HOLD) && chan_ready_in) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

  // Word, header and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_q <= '0;
      hdr_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (load_head) begin
        chan_q <= chan_head;
        hdr_q  <= flit_in[HEADER_FULL-1:0];
      end else if (load_body) begin
        chan_q <= chan_body;
      end
      err_q <= err_q | set_err;
    end
  end

endmodule
